// File: rtl/ecg_sample_pacer.sv
// ECG sample pacer: issues one-sample requests to a recording source at a programmable
// period, captures the answers and forwards them to the core through a small FWFT FIFO.
module ecg_sample_pacer #(
  parameter int DATA_WIDTH = 11,
  parameter int CTR_WIDTH  = 24,
  parameter int DIV_WIDTH  = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DIV_WIDTH-1:0]  div_val,
  input  logic [CTR_WIDTH-1:0]  num_samples,
  output logic                  src_req,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTR_WIDTH-1:0]  sample_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic                  src_empty
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int TO_W   = $clog2(TIMEOUT) + 1;
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
  // The request cycle counts as the first silent cycle, so the last WAIT cycle is TIMEOUT-2.
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  tick_q, tick_d;
  logic [CTR_WIDTH-1:0]  num_q, num_d;
  logic [CTR_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [TO_W-1:0]       to_q, to_d;
  logic                  overrun_q, overrun_d;
  logic                  src_empty_q, src_empty_d;

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]     fcount_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic slot, push, pop, fifo_empty, fifo_full;

  assign slot       = (tick_q == '0);
  assign fifo_empty = (fcount_q == '0);
  assign fifo_full  = (fcount_q == FIFO_FULL);
  assign pop        = !fifo_empty && out_ready;
  assign cnt_inc    = cnt_q + CTR_WIDTH'(1);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    tick_d      = tick_q;
    to_d        = to_q;
    overrun_d   = overrun_q;
    src_empty_d = src_empty_q;
    push        = 1'b0;
    src_req     = 1'b0;
    done        = 1'b0;

    if (state_q == S_ARM || state_q == S_WAIT) begin
      tick_d = slot ? (div_q - DIV_WIDTH'(1)) : (tick_q - DIV_WIDTH'(1));
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop && fifo_empty) begin
          div_d       = (div_val == '0) ? DIV_WIDTH'(1) : div_val;
          num_d       = num_samples;
          cnt_d       = '0;
          overrun_d   = 1'b0;
          src_empty_d = 1'b0;
          tick_d      = '0;
          state_d     = (num_samples == '0) ? S_DONE : S_ARM;
        end
      end

      S_ARM: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (slot) begin
          if (!fifo_full) begin
            src_req = 1'b1;
            to_d    = '0;
            state_d = S_WAIT;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        // stop takes priority: a sample strobed in the stop cycle is dropped too.
        if (stop) begin
          state_d = S_DONE;
        end else begin
          if (slot) overrun_d = 1'b1;
          to_d = to_q + TO_W'(1);
          if (src_valid) begin
            push    = 1'b1;
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == num_q) ? S_DONE : S_ARM;
          end else if (to_q == TO_LAST) begin
            src_empty_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      tick_q      <= '0;
      to_q        <= '0;
      overrun_q   <= 1'b0;
      src_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      to_q        <= to_d;
      overrun_q   <= overrun_d;
      src_empty_q <= src_empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcount_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fcount_q <= fcount_q + FCNT_W'(1);
        2'b01:   fcount_q <= fcount_q - FCNT_W'(1);
        default: fcount_q <= fcount_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= src_data;
  end

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign sample_cnt = cnt_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;
  assign src_empty  = src_empty_q;

endmodule
